// File: rtl/board_mem_arbiter_pkg.sv
// Shared game types for the board-state RAM arbiter: FSM state, requester count
// and indices, and the modulo-3 rotation helper used by the winner picker.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int NUM_BOARD_REQ = 3;

    localparam int REQ_MINEGEN = 0;
    localparam int REQ_CLICK   = 1;
    localparam int REQ_REVEAL  = 2;

    // Pointer value after reset/flush: the scan then starts at requester 0.
    localparam logic [1:0] PTR_RESET = 2'd2;

    // Next requester index, wrapping 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Requester-side and RAM-side bus of the board memory arbiter.
// slave = arbiter view, master = requesters/RAM view.
interface board_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    import game_pkg::*;

    logic [NUM_BOARD_REQ-1:0]        req;
    logic [NUM_BOARD_REQ-1:0]        lock;
    logic [NUM_BOARD_REQ-1:0]        we;
    logic [NUM_BOARD_REQ*ADDR_W-1:0] addr;
    logic [NUM_BOARD_REQ*DATA_W-1:0] wdata;
    logic [NUM_BOARD_REQ-1:0]        gnt;
    logic [NUM_BOARD_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]               rdata;

    logic                            mem_en;
    logic                            mem_we;
    logic [ADDR_W-1:0]               mem_addr;
    logic [DATA_W-1:0]               mem_wdata;
    logic [DATA_W-1:0]               mem_rdata;

    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/board_arb_pick.sv
// Combinational winner picker: first set req bit scanning ptr+1, ptr+2, ptr+3
// (mod 3). A constant ptr of 2 turns this into fixed priority 0 > 1 > 2.
module board_arb_pick
    import game_pkg::*;
(
    input  logic [NUM_BOARD_REQ-1:0] req,
    input  logic [1:0]               ptr,
    output logic [NUM_BOARD_REQ-1:0] win,
    output logic [1:0]               win_idx
);

    logic [1:0] cand;
    logic       found;

    // Rotating scan; the first hit wins, later hits are ignored.
    always_comb begin
        win_idx = 2'd0;
        found   = 1'b0;
        cand    = ptr;
        win     = '0;
        for (int k = 0; k < NUM_BOARD_REQ; k++) begin
            cand = rr_next(cand);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        win[win_idx] = found;
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board-state RAM arbiter/sequencer for mine generator, click handler and
// flood-fill reveal. Each access is one memory cycle (ACCESS) plus one
// response cycle (RESP); a locked owner is re-granted ahead of rotation.
// Macro BOARD_ARB_ROUND_ROBIN_EN: defined = round-robin, undefined = fixed
// priority (bit 0 highest) with no rotation pointer.
module board_mem_arbiter
    import game_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arb_en,
    input  logic                flush,
    board_mem_arbiter_if.slave  bus
);

    arb_state_t               state;
    logic [1:0]               owner;
    logic [1:0]               pick_ptr;
    logic [NUM_BOARD_REQ-1:0] pick_win;
    logic [1:0]               pick_idx;
    logic                     lock_hold;
    logic                     do_grant;
    logic [1:0]               sel_idx;
    logic [NUM_BOARD_REQ-1:0] sel_onehot;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;

`ifdef BOARD_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr;
    assign pick_ptr = ptr;
`else
    assign pick_ptr = PTR_RESET;
`endif

    board_arb_pick u_pick (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

    // Locked owner keeps the RAM only while still requesting and enabled.
    assign lock_hold = (state == RESP) && arb_en && bus.req[owner] && bus.lock[owner];
    assign do_grant  = arb_en && (|bus.req);

    // Winner selection: locked owner bypasses the rotation.
    always_comb begin
        sel_idx    = lock_hold ? owner : pick_idx;
        sel_onehot = pick_win;
        if (lock_hold) begin
            sel_onehot        = '0;
            sel_onehot[owner] = 1'b1;
        end
    end

    assign sel_addr  = bus.addr[sel_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = bus.wdata[sel_idx*DATA_W +: DATA_W];

    // Read data is only driven while a read response is being returned.
    assign bus.rdata = (|bus.rvalid) ? bus.mem_rdata : '0;

    // Sequencer FSM with registered strobes; flush aborts everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= '0;
`ifdef BOARD_ARB_ROUND_ROBIN_EN
            ptr           <= PTR_RESET;
`endif
            bus.gnt       <= '0;
            bus.rvalid    <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (flush) begin
            state         <= IDLE;
            owner         <= '0;
`ifdef BOARD_ARB_ROUND_ROBIN_EN
            ptr           <= PTR_RESET;
`endif
            bus.gnt       <= '0;
            bus.rvalid    <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.gnt    <= '0;
            bus.rvalid <= '0;
            bus.mem_en <= 1'b0;
            case (state)
                ACCESS: begin
                    // RAM data shows up next cycle; flag it only for reads.
                    bus.rvalid[owner] <= ~bus.mem_we;
                    state             <= RESP;
                end
                IDLE, RESP: begin
                    if (do_grant) begin
                        owner         <= sel_idx;
`ifdef BOARD_ARB_ROUND_ROBIN_EN
                        ptr           <= sel_idx;
`endif
                        bus.gnt       <= sel_onehot;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.we[sel_idx];
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        state         <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Arbiter and sequencer for the single-port board-state RAM. It shares the RAM between three requesters: mine generator, click handler and flood-fill reveal engine. It sits between those engines and the board memory, and main_fsm gates it per game state through `arb_en` and `flush`. Each access is one memory cycle plus one response cycle, and locked read-modify-write sequences are supported.

## Interface
- `ADDR_W`, 10: board cell address width (up to 32x32 cells).
- `DATA_W`, 8: cell word width (mine, revealed, flag, 4-bit neighbour count, spare).
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-high reset.
- `arb_en  in  1`: from main_fsm; when 0, no new grants are issued.
- `flush  in  1`: from main_fsm (retry/new game); synchronous abort of all activity.
- `req  in  3`: per-requester access request; bit 0 mine generator, bit 1 click, bit 2 reveal.
- `lock  in  3`: per-requester hold-ownership flag, qualified by `req`.
- `we  in  3`: per-requester write enable (1 = write, 0 = read).
- `addr  in  3*ADDR_W`: packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- `wdata  in  3*DATA_W`: packed write data, sliced the same way as `addr`.
- `gnt  out  3`: one-hot grant pulse, high during the memory cycle.
- `rvalid  out  3`: one-hot read-data-valid pulse.
- `rdata  out  DATA_W`: read data, valid while any `rvalid` bit is high.
- `mem_en`, `mem_we`  out  1: RAM strobes.
- `mem_addr  out  ADDR_W`, `mem_wdata  out  DATA_W`: RAM address and write data.
- `mem_rdata  in  DATA_W`: RAM output, valid one cycle after `mem_en`.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - If `arb_en` is high and `req` is non-zero at an edge: pick a winner and register `owner`, `mem_addr`, `mem_we`, `mem_wdata` from its slices. Go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `mem_en=1` and `gnt[owner]=1` for exactly this cycle.
  - Always go to RESP next.
- **RESP**
  - If the access was a read, `rvalid[owner]=1` and `rdata=mem_rdata`.
  - At the closing edge, re-arbitrate:
    - If `arb_en`, `req[owner]` and `lock[owner]` are all high: re-grant the owner, bypassing rotation. Go to ACCESS.
    - Else if `arb_en` is high and any `req` is high: pick a normal winner. Go to ACCESS.
    - Else go to IDLE.
- **Round-robin winner:** the first set `req` bit scanning `ptr+1`, `ptr+2`, `ptr+3` modulo 3. `ptr` is updated to the winner on every grant, including lock re-grants.
- **Requester rules:**
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen.
  - Deassert `req`, or present the next access, in the cycle after `gnt`.
  - `lock` is sampled only at RESP exit.
- **`arb_en` low mid-operation:** an in-flight ACCESS/RESP completes, including its `rvalid`. `lock` is ignored and the FSM returns to IDLE.
- **`flush` high at an edge:** highest priority below reset.
  - State goes to IDLE, `ptr` to 2, and all outputs to 0 on the next cycle.
  - A read in flight gets no `rvalid`.
- **`rst`:** state IDLE, `ptr`=2, `owner`=0, every output 0.

## Timing
- First grant: `req` sampled at edge N; `gnt` and `mem_en` are high in cycle N+1; `rvalid` is high in cycle N+2.
- Sustained throughput: one access per 2 cycles, back-to-back with no idle cycle when requests are pending.
- All outputs are registered except `rdata`, which is a combinational pass-through of `mem_rdata`.
- `gnt`, `rvalid` and `mem_en` are never high for more than one consecutive cycle per access. At most one bit of `gnt` or `rvalid` is set at any time.

## Configuration
- Macro `BOARD_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration as described above.
- **Undefined:** fixed priority, bit 0 > bit 1 > bit 2. `ptr` is not implemented. The lock behaviour is unchanged.

## Structure
- Shared package `game_pkg` holds:
  - `arb_state_t` (IDLE, ACCESS, RESP).
  - `NUM_BOARD_REQ = 3`.
  - Requester indices `REQ_MINEGEN = 0`, `REQ_CLICK = 1`, `REQ_REVEAL = 2`.
- One combinational sub-module, `board_arb_pick`:
  - Inputs: `req` and `ptr`.
  - Outputs: a one-hot winner and its index.
  - Reused for both the round-robin and the fixed-priority variant.

## Test plan
- **Single read:** reset, `arb_en=1`; `req=3'b010`, `we=0`, `addr[1]=10'h05A`, RAM word 8'h3C → `gnt=3'b010` one cycle later, `mem_addr=10'h05A`; the next cycle has `rvalid=3'b010` and `rdata=8'h3C`.
- **Round-robin fairness:** `req=3'b111` held for 6 grants → grant order 0,1,2,0,1,2, one grant every 2 cycles. With the macro undefined the order is 0,0,0,….
- **Lock:** requester 2 holds `req` and `lock` while requesters 0 and 1 also request → 4 consecutive grants to requester 2. After `lock` drops, the next grant goes to requester 0.
- **Gating:** `arb_en=0` with `req=3'b001` for 10 cycles → `gnt` stays 0. Raising `arb_en` → `gnt=3'b001` one cycle later.
- **Flush during read:** `flush=1` in the ACCESS cycle of a read → no `rvalid`, all outputs 0 the next cycle. The next request is arbitrated starting from requester 0.
- **Async reset:** assert `rst` mid-RESP, between clock edges → all outputs 0 immediately, FSM in IDLE.
